// File: rtl/ifu_pkg.sv
// Shared instruction-fetch constants: default reset/exception vectors and PC step.
package ifu_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_PC   = 32'h0000_4180;
  localparam int unsigned INSTR_BYTES      = 4;

endpackage

// File: rtl/pc_fifo.sv
// DEPTH x WIDTH circular PC store with push/pop/flush and an entry count.
module pc_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;

  // Data array carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (i_push && !reset && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/pc_fetch_queue.sv
// Sequential PC generator feeding a small fetch queue, with redirect/exception flush.
module pc_fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(DEFAULT_EXC_PC)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [WIDTH-1:0]       redirect_pc,
  input  logic                   exc_req,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_pc,
  output logic                   out_adel,
  output logic [$clog2(DEPTH):0] level,
  output logic [WIDTH-1:0]       fetch_pc
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] w_fetch_pc_d;
  logic             w_flush;
  logic             w_push;
  logic             w_pop;
  logic [CntW-1:0]  w_count;
  logic [WIDTH-1:0] w_head;

  assign w_flush = exc_req || redirect_valid;
  assign w_pop   = (w_count != '0) && out_ready && !w_flush;
  // Full queue still accepts a push when the head leaves on the same edge.
  assign w_push  = fetch_en && !w_flush && ((w_count < CntW'(DEPTH)) || w_pop);

  always_comb begin
    w_fetch_pc_d = r_fetch_pc;
    if (exc_req) begin
      w_fetch_pc_d = EXC_PC;
    end else if (redirect_valid) begin
      w_fetch_pc_d = redirect_pc;
    end else if (w_push) begin
      w_fetch_pc_d = r_fetch_pc + WIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
    end else begin
      r_fetch_pc <= w_fetch_pc_d;
    end
  end

  pc_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (r_fetch_pc),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign out_valid = (w_count != '0);
  assign out_pc    = w_head;
  assign out_adel  = (w_head[1:0] != 2'b00);
  assign level     = w_count;
  assign fetch_pc  = r_fetch_pc;

endmodule
